// File: rtl/i2s_tx_frame_scheduler.sv
// i2s_tx_frame_scheduler
// Generates BCLK/LRCLK for the parallel-to-I2S serializer from CLK. It
// double-buffers stereo pairs from upstream over IN_VALID/IN_READY and presents
// the channel word on DATA_WORD at each LRCLK transition. UNDERRUN flags a
// frame that starts with no buffered pair.
//
// Optional build macro: I2S_TX_HOLD_LAST_EN
//   When defined, an underrun frame repeats the previous frame's words.
//   When undefined, an underrun frame outputs zeros on both channels.
//
// state | meaning
// IDLE  | clocks parked low, counters at 0, waiting for ENABLE
// RUN   | generating BCLK/LRCLK, one frame_load per frame boundary
module i2s_tx_frame_scheduler #(
    parameter int WORD_LEN = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                ENABLE,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [WORD_LEN-1:0] IN_LEFT,
    input  logic [WORD_LEN-1:0] IN_RIGHT,
    output logic                BCLK,
    output logic                LRCLK,
    output logic [WORD_LEN-1:0] DATA_WORD,
    output logic                FRAME_START,
    output logic                UNDERRUN,
    output logic                BUSY
);

    localparam int            BW       = (WORD_LEN > 1) ? $clog2(WORD_LEN) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WORD_LEN - 1);
    localparam logic [7:0]    DIV_LAST = 8'(BCLK_DIV - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t              state;
    logic [7:0]          div_cnt;
    logic [BW-1:0]       bit_cnt;
    logic                pair_full;
    logic [WORD_LEN-1:0] buf_left;
    logic [WORD_LEN-1:0] buf_right;
    logic [WORD_LEN-1:0] frame_left;
    logic [WORD_LEN-1:0] frame_right;
    logic                div_wrap;
    logic                fall_evt;
    logic                frame_end;
    logic                frame_load;
    logic                xfer;

    // Event decode: BCLK divider wrap, falling edge, frame boundary and buffer consume.
    always_comb begin
        div_wrap   = (state == S_RUN) && (div_cnt == DIV_LAST);
        fall_evt   = div_wrap && BCLK;
        frame_end  = fall_evt && (bit_cnt == BIT_LAST) && LRCLK;
        frame_load = RST_N && ENABLE && ((state == S_IDLE) || frame_end);
    end

    // The consume cycle frees the single entry, so a new pair may land in the same cycle.
    assign IN_READY = !pair_full || frame_load;
    assign xfer     = IN_VALID && IN_READY;
    assign BUSY     = (state == S_RUN);

    // Pair buffer, frame latches, clock generation and the IDLE/RUN sequencer.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            pair_full   <= 1'b0;
            buf_left    <= '0;
            buf_right   <= '0;
            frame_left  <= '0;
            frame_right <= '0;
            BCLK        <= 1'b0;
            LRCLK       <= 1'b0;
            DATA_WORD   <= '0;
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;
        end else begin
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;

            if (xfer) begin
                pair_full <= 1'b1;
                buf_left  <= IN_LEFT;
                buf_right <= IN_RIGHT;
            end else if (frame_load) begin
                pair_full <= 1'b0;
            end

            if (frame_load) begin
                FRAME_START <= 1'b1;
                if (pair_full) begin
                    frame_left  <= buf_left;
                    frame_right <= buf_right;
                    DATA_WORD   <= buf_left;
                end else begin
                    UNDERRUN <= 1'b1;
`ifdef I2S_TX_HOLD_LAST_EN
                    DATA_WORD <= frame_left;
`else
                    frame_left  <= '0;
                    frame_right <= '0;
                    DATA_WORD   <= '0;
`endif
                end
            end

            case (state)
                S_IDLE: begin
                    BCLK    <= 1'b0;
                    LRCLK   <= 1'b0;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    if (frame_load) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        BCLK    <= !BCLK;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                    if (fall_evt) begin
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            LRCLK   <= !LRCLK;
                            if (!LRCLK) begin
                                DATA_WORD <= frame_right;
                            end else if (!ENABLE) begin
                                // Frame completed with no run request: park in IDLE.
                                state <= S_IDLE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2s_tx_frame_scheduler.sv
// Testbench for i2s_tx_frame_scheduler (WORD_LEN=16, BCLK_DIV=2).
// The reference model tracks each frame as a phase count since its frame_load
// and derives BCLK/LRCLK/DATA_WORD from that phase arithmetically.
module tb_i2s_tx_frame_scheduler;

    localparam int WL  = 16;
    localparam int DIV = 2;
    localparam int H   = WL * 2 * DIV;
    localparam int F   = 2 * H;

    logic          CLK      = 1'b0;
    logic          RST_N    = 1'b0;
    logic          ENABLE   = 1'b0;
    logic          IN_VALID = 1'b0;
    logic [WL-1:0] IN_LEFT  = '0;
    logic [WL-1:0] IN_RIGHT = '0;
    logic          IN_READY;
    logic          BCLK;
    logic          LRCLK;
    logic [WL-1:0] DATA_WORD;
    logic          FRAME_START;
    logic          UNDERRUN;
    logic          BUSY;

    always #5 CLK = ~CLK;

    i2s_tx_frame_scheduler #(.WORD_LEN(WL), .BCLK_DIV(DIV)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .IN_VALID(IN_VALID),
        .IN_READY(IN_READY), .IN_LEFT(IN_LEFT), .IN_RIGHT(IN_RIGHT),
        .BCLK(BCLK), .LRCLK(LRCLK), .DATA_WORD(DATA_WORD),
        .FRAME_START(FRAME_START), .UNDERRUN(UNDERRUN), .BUSY(BUSY)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit            m_run  = 1'b0;
    bit            m_full = 1'b0;
    bit            m_uf   = 1'b0;
    int            m_t    = 0;
    logic [WL-1:0] m_bl   = '0;
    logic [WL-1:0] m_br   = '0;
    logic [WL-1:0] m_cl   = '0;
    logic [WL-1:0] m_cr   = '0;
    logic [WL-1:0] m_dw   = '0;
    logic [WL+4:0] exp_v  = '0;
    logic [WL+4:0] got_v;
    bit            exp_ready = 1'b1;
    logic          obs_ready;

    assign got_v = {BCLK, LRCLK, FRAME_START, UNDERRUN, BUSY, DATA_WORD};

    // One clock: predict ready/consume, take the edge, update the model, land on negedge.
    task automatic advance();
        bit fl;
        bit xfer;
        #1;
        fl        = RST_N && ENABLE && (!m_run || m_t == F - 1);
        exp_ready = !m_full || fl;
        obs_ready = IN_READY;
        xfer      = RST_N && IN_VALID && exp_ready;
        @(posedge CLK);
        cyc++;
        if (!RST_N) begin
            m_run = 0; m_full = 0; m_t = 0; m_uf = 0;
            m_cl = '0; m_cr = '0; m_dw = '0; fl = 0;
        end else begin
            if (fl) begin
                if (m_full) begin
                    m_cl = m_bl; m_cr = m_br; m_uf = 0;
                end else begin
                    m_uf = 1;
`ifndef I2S_TX_HOLD_LAST_EN
                    m_cl = '0; m_cr = '0;
`endif
                end
                m_run = 1; m_t = 0;
            end else if (m_run) begin
                if (m_t == F - 1) begin m_run = 0; m_t = 0; end
                else m_t++;
            end
            if (xfer) begin m_full = 1; m_bl = IN_LEFT; m_br = IN_RIGHT; end
            else if (fl) m_full = 0;
        end
        if (m_run) m_dw = (m_t < H) ? m_cl : m_cr;
        exp_v = {(m_run && ((m_t / DIV) % 2 == 1)), (m_run && m_t >= H),
                 fl, (fl && m_uf), m_run, m_dw};
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_N = 0; ENABLE = 1; IN_VALID = 1;
        IN_LEFT = WL'($urandom); IN_RIGHT = WL'($urandom);
        repeat (3) advance();
        total++; if (got_v !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", got_v); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", IN_READY); end
        ENABLE = 0; IN_VALID = 0; RST_N = 1;
        advance();
        total++; if (got_v !== exp_v) begin bad++; $display("FAIL reset_release got=%h exp=%h", got_v, exp_v); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", IN_READY); end
    endtask

    task automatic test_first_frame();
        int fs_n = 0;
        int lr_n = 0;
        int fs_at[3];
        logic [WL-1:0] fs_dw[3];
        bit fs_ur[3];
        int lr_at[2];
        logic [WL-1:0] lr_dw[2];
        int falls = 0;
        int last_b;
        int n;
        logic pb = 1'b0;
        logic pl = 1'b0;
        logic [WL-1:0] exp2_l;
        logic [WL-1:0] exp2_r;
        IN_VALID = 1; IN_LEFT = 16'h1234; IN_RIGHT = 16'hABCD;
        advance();
        total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL idle_push_ready got=%b exp=%b", obs_ready, exp_ready); end
        IN_VALID = 0; IN_LEFT = WL'($urandom); IN_RIGHT = WL'($urandom);
        #1;
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL full_idle_ready got=%b exp=0", IN_READY); end
        ENABLE = 1;
        last_b = cyc + 1;
        for (int i = 0; i < 2 * F + 4; i++) begin
            advance();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL frame_cycle cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL frame_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready); end
            if (FRAME_START === 1'b1) begin
                if (fs_n < 3) begin fs_at[fs_n] = cyc; fs_dw[fs_n] = DATA_WORD; fs_ur[fs_n] = UNDERRUN; end
                fs_n++;
            end
            if (pb === 1'b1 && BCLK === 1'b0) falls++;
            if (BCLK !== pb) begin
                total++; if (cyc - last_b != DIV) begin bad++; $display("FAIL bclk_half cyc=%0d got=%0d exp=%0d", cyc, cyc - last_b, DIV); end
                last_b = cyc;
            end
            if (LRCLK !== pl) begin
                total++; if (!(pb === 1'b1 && BCLK === 1'b0)) begin bad++; $display("FAIL lrclk_align cyc=%0d bclk_prev=%b bclk=%b exp=1/0", cyc, pb, BCLK); end
                total++; if (falls != WL) begin bad++; $display("FAIL falls_per_slot got=%0d exp=%0d", falls, WL); end
                falls = 0;
                if (LRCLK === 1'b1 && lr_n < 2) begin lr_at[lr_n] = cyc; lr_dw[lr_n] = DATA_WORD; lr_n++; end
            end
            pb = BCLK; pl = LRCLK;
        end
`ifdef I2S_TX_HOLD_LAST_EN
        exp2_l = 16'h1234; exp2_r = 16'hABCD;
`else
        exp2_l = 16'h0000; exp2_r = 16'h0000;
`endif
        total++; if (fs_n != 3) begin bad++; $display("FAIL frame_start_count got=%0d exp=3", fs_n); end
        total++; if (lr_n != 2) begin bad++; $display("FAIL lrclk_rise_count got=%0d exp=2", lr_n); end
        if (fs_n >= 3 && lr_n >= 2) begin
            total++; if (fs_dw[0] !== 16'h1234) begin bad++; $display("FAIL first_left got=%h exp=1234", fs_dw[0]); end
            total++; if (fs_ur[0] !== 1'b0) begin bad++; $display("FAIL first_underrun got=%b exp=0", fs_ur[0]); end
            total++; if (lr_at[0] - fs_at[0] != H) begin bad++; $display("FAIL lrclk_rise_delay got=%0d exp=%0d", lr_at[0] - fs_at[0], H); end
            total++; if (lr_dw[0] !== 16'hABCD) begin bad++; $display("FAIL first_right got=%h exp=abcd", lr_dw[0]); end
            total++; if (fs_at[1] - fs_at[0] != F) begin bad++; $display("FAIL frame_period got=%0d exp=%0d", fs_at[1] - fs_at[0], F); end
            total++; if (fs_at[2] - fs_at[1] != F) begin bad++; $display("FAIL frame_period2 got=%0d exp=%0d", fs_at[2] - fs_at[1], F); end
            total++; if (fs_ur[1] !== 1'b1) begin bad++; $display("FAIL second_underrun got=%b exp=1", fs_ur[1]); end
            total++; if (fs_dw[1] !== exp2_l) begin bad++; $display("FAIL second_left got=%h exp=%h", fs_dw[1], exp2_l); end
            total++; if (lr_dw[1] !== exp2_r) begin bad++; $display("FAIL second_right got=%h exp=%h", lr_dw[1], exp2_r); end
        end
        ENABLE = 0;
        n = 0;
        while (BUSY === 1'b1 && n < F + 8) begin
            advance(); n++;
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL first_drain cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
        end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL first_drain_timeout busy=%b exp=0", BUSY); end
    endtask

    task automatic test_back_to_back();
        logic [WL-1:0] base;
        logic [WL-1:0] got_l[4];
        int k = 0;
        int fs_n = 0;
        int acc = 0;
        int n = 0;
        base = WL'($urandom);
        IN_VALID = 1; IN_LEFT = base; IN_RIGHT = ~base;
        advance();
        if (IN_VALID && exp_ready) k++;
        IN_LEFT = base + WL'(k); IN_RIGHT = ~(base + WL'(k));
        ENABLE = 1;
        while (fs_n < 4 && n < 4 * F + 8) begin
            advance(); n++;
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL b2b_cycle cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
            total++; if (obs_ready !== exp_ready) begin bad++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, obs_ready, exp_ready); end
            if (IN_VALID && obs_ready === 1'b1) acc++;
            if (IN_VALID && exp_ready) k++;
            if (FRAME_START === 1'b1) begin
                if (fs_n < 4) got_l[fs_n] = DATA_WORD;
                fs_n++;
            end
            if (k >= 4) IN_VALID = 0;
            else begin IN_LEFT = base + WL'(k); IN_RIGHT = ~(base + WL'(k)); end
        end
        total++; if (fs_n != 4) begin bad++; $display("FAIL b2b_frames got=%0d exp=4", fs_n); end
        total++; if (k != 4) begin bad++; $display("FAIL b2b_accepted_model got=%0d exp=4", k); end
        total++; if (acc != 3) begin bad++; $display("FAIL b2b_ready_pulses got=%0d exp=3", acc); end
        for (int j = 0; j < 4 && j < fs_n; j++) begin
            total++; if (got_l[j] !== base + WL'(j)) begin bad++; $display("FAIL b2b_order idx=%0d got=%h exp=%h", j, got_l[j], base + WL'(j)); end
        end
        ENABLE = 0; IN_VALID = 0;
        n = 0;
        while (BUSY === 1'b1 && n < F + 8) begin
            advance(); n++;
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL b2b_drain cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
        end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_drain_timeout busy=%b exp=0", BUSY); end
    endtask

    task automatic test_disable_mid();
        localparam int T = H + 5 * 2 * DIV;
        int n = 0;
        int fs_after = 0;
        bit reached = 0;
        IN_VALID = 1; IN_LEFT = WL'($urandom); IN_RIGHT = WL'($urandom);
        advance();
        IN_VALID = 0;
        ENABLE = 1;
        while (!reached && n < F + 8) begin
            advance();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL dis_cycle cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
            IN_VALID = (n == 0);
            IN_LEFT = WL'($urandom); IN_RIGHT = WL'($urandom);
            n++;
            if (m_run && m_t == T) reached = 1;
        end
        IN_VALID = 0;
        total++; if (!reached) begin bad++; $display("FAIL dis_reach got=0 exp=1"); end
        ENABLE = 0;
        n = 0;
        while (BUSY === 1'b1 && n < F + 8) begin
            advance(); n++;
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL dis_drain cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
            if (FRAME_START === 1'b1) fs_after++;
        end
        total++; if (n != F - T) begin bad++; $display("FAIL dis_drain_len got=%0d exp=%0d", n, F - T); end
        repeat (20) begin
            advance();
            if (FRAME_START === 1'b1) fs_after++;
        end
        total++; if (fs_after != 0) begin bad++; $display("FAIL dis_no_frame got=%0d exp=0", fs_after); end
        total++; if ({BCLK, LRCLK, BUSY} !== 3'b000) begin bad++; $display("FAIL dis_idle got=%b exp=000", {BCLK, LRCLK, BUSY}); end
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL dis_buffer_kept got=%b exp=0", IN_READY); end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        bit reached = 0;
        ENABLE = 1;
        while (!reached && n < F) begin
            advance();
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL rst_cycle cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
            IN_VALID = (n == 0);
            IN_LEFT = WL'($urandom); IN_RIGHT = WL'($urandom);
            n++;
            if (m_run && m_t == 30) reached = 1;
        end
        IN_VALID = 0;
        #1;
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL rst_pre_full got=%b exp=0", IN_READY); end
        RST_N = 0;
        advance();
        total++; if (got_v !== '0) begin bad++; $display("FAIL rst_mid_outputs got=%h exp=0", got_v); end
        total++; if (IN_READY !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", IN_READY); end
        repeat (3) begin
            advance();
            total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_hold_idle busy=%b exp=0", BUSY); end
        end
        RST_N = 1;
        advance();
        total++; if (got_v !== exp_v) begin bad++; $display("FAIL rst_restart got=%h exp=%h", got_v, exp_v); end
        total++; if (UNDERRUN !== 1'b1) begin bad++; $display("FAIL rst_buffer_discard underrun=%b exp=1", UNDERRUN); end
        ENABLE = 0;
        n = 0;
        while (BUSY === 1'b1 && n < F + 8) begin
            advance(); n++;
            total++; if (got_v !== exp_v) begin bad++; $display("FAIL rst_drain cyc=%0d got=%h exp=%h", cyc, got_v, exp_v); end
        end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_drain_timeout busy=%b exp=0", BUSY); end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_disable_mid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
